// File: rtl/md_pkg.sv
// Shared multiply/divide definitions.
// Opcode encodings and default latencies.
package md_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  localparam int MUL_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;

endpackage

// File: rtl/md_if.sv
// Bundle between the E stage and the
// multiply/divide unit.
interface md_if #(
  parameter int WIDTH = 32
);
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output op, a, b,
    input  busy, hi, lo
  );

  modport slave (
    input  op, a, b,
    output busy, hi, lo
  );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning
// the HI/LO architectural registers.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input logic clk,
  input logic reset,
  md_if.slave bus
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  localparam logic [WIDTH-1:0] ONE =
    {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state, state_nx;
  logic [3:0]       cnt, cnt_nx;
  logic [WIDTH-1:0] hi, hi_nx;
  logic [WIDTH-1:0] lo, lo_nx;
  logic [WIDTH-1:0] pend_hi, pend_hi_nx;
  logic [WIDTH-1:0] pend_lo, pend_lo_nx;
  logic             pend_we, pend_we_nx;

  logic             is_mul, is_div, start;
  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, d_mag;
  logic [WIDTH-1:0] q_mag, r_mag;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             res_we;

  assign is_mul = (bus.op == MD_MULT)
               || (bus.op == MD_MULTU);
  assign is_div = (bus.op == MD_DIV)
               || (bus.op == MD_DIVU);
  assign start  = (is_mul || is_div)
               && (state == IDLE);
  assign bus.busy = start || (state == BUSY);
  assign bus.hi = hi;
  assign bus.lo = lo;

  // Sign-extended operands make the low
  // 2*WIDTH bits of the product signed.
  assign prod_s =
    {{WIDTH{bus.a[WIDTH-1]}}, bus.a} *
    {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
  assign prod_u =
    {{WIDTH{1'b0}}, bus.a} *
    {{WIDTH{1'b0}}, bus.b};

  // Divide on magnitudes; MIN/-1 falls out
  // as LO=MIN, HI=0 without a special case.
  assign a_neg = (bus.op == MD_DIV) && bus.a[WIDTH-1];
  assign b_neg = (bus.op == MD_DIV) && bus.b[WIDTH-1];
  assign a_mag = a_neg ? -bus.a : bus.a;
  assign b_mag = b_neg ? -bus.b : bus.b;
  assign d_mag = (bus.b == '0) ? ONE : b_mag;
  assign q_mag = a_mag / d_mag;
  assign r_mag = a_mag % d_mag;

  // Select the result captured at start.
  always_comb begin
    res_hi = '0;
    res_lo = '0;
    res_we = 1'b0;
    unique case (1'b1)
      bus.op == MD_MULT: begin
        {res_hi, res_lo} = prod_s;
        res_we = 1'b1;
      end
      bus.op == MD_MULTU: begin
        {res_hi, res_lo} = prod_u;
        res_we = 1'b1;
      end
      is_div: begin
        res_lo = (a_neg ^ b_neg) ? -q_mag : q_mag;
        res_hi = a_neg ? -r_mag : r_mag;
        res_we = (bus.b != '0);
      end
      default: ;
    endcase
  end

  // Next state, counter, pending and HI/LO.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    hi_nx      = hi;
    lo_nx      = lo;
    pend_hi_nx = pend_hi;
    pend_lo_nx = pend_lo;
    pend_we_nx = pend_we;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx   = BUSY;
          cnt_nx     = is_mul ? 4'(MUL_CYCLES)
                              : 4'(DIV_CYCLES);
          pend_hi_nx = res_hi;
          pend_lo_nx = res_lo;
          pend_we_nx = res_we;
        end else if (bus.op == MD_MTHI) begin
          hi_nx = bus.a;
        end else if (bus.op == MD_MTLO) begin
          lo_nx = bus.a;
        end
      end
      BUSY: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nx = IDLE;
          if (pend_we) begin
            hi_nx = pend_hi;
            lo_nx = pend_lo;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Register state; reset drops any
  // operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_we <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      hi      <= hi_nx;
      lo      <= lo_nx;
      pend_hi <= pend_hi_nx;
      pend_lo <= pend_lo_nx;
      pend_we <= pend_we_nx;
    end
  end

endmodule

// File: rtl/execute_md_stage.sv
// E stage multiply/divide slice and the
// E-to-M pipeline registers.
module execute_md_stage
  import md_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      E_PC,
  input  logic [31:0]      E_Ins,
  input  logic [WIDTH-1:0] E_A,
  input  logic [WIDTH-1:0] E_B,
  input  logic [3:0]       E_md_op,
  input  logic             E_clear,
  output logic             E_busy,
  output logic [WIDTH-1:0] E_md_out,
  output logic [31:0]      M_PC,
  output logic [31:0]      M_Ins,
  output logic [WIDTH-1:0] M_md_Y,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  md_if #(.WIDTH(WIDTH)) md ();

  assign md.op  = E_md_op;
  assign md.a   = E_A;
  assign md.b   = E_B;
  assign E_busy = md.busy;
  assign HI     = md.hi;
  assign LO     = md.lo;

  md_unit #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md (
    .clk   (clk),
    .reset (reset),
    .bus   (md)
  );

  // MFHI/MFLO read the current HI/LO.
  always_comb begin
    E_md_out = '0;
    unique case (1'b1)
      E_md_op == MD_MFHI: E_md_out = md.hi;
      E_md_op == MD_MFLO: E_md_out = md.lo;
      default: ;
    endcase
  end

  // E-to-M registers advance every cycle;
  // a clear injects a bubble.
  always_ff @(posedge clk) begin
    if (reset || E_clear) begin
      M_PC   <= '0;
      M_Ins  <= '0;
      M_md_Y <= '0;
    end else begin
      M_PC   <= E_PC;
      M_Ins  <= E_Ins;
      M_md_Y <= E_md_out;
    end
  end

endmodule

// File: tb/tb_execute_md_stage.sv
// Directed and random checks of the E stage
// multiply/divide slice against a model.
module tb_execute_md_stage;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] E_PC, E_Ins;
  logic        E_clear;
  logic [31:0] E_md_out, M_PC, M_Ins, M_md_Y;

  md_if #(.WIDTH(32)) bus ();

  int errors = 0;
  int checks = 0;
  logic [31:0] mdl_hi = '0;
  logic [31:0] mdl_lo = '0;

  always #5 clk = ~clk;

  execute_md_stage dut (
    .clk      (clk),
    .reset    (reset),
    .E_PC     (E_PC),
    .E_Ins    (E_Ins),
    .E_A      (bus.a),
    .E_B      (bus.b),
    .E_md_op  (bus.op),
    .E_clear  (E_clear),
    .E_busy   (bus.busy),
    .E_md_out (E_md_out),
    .M_PC     (M_PC),
    .M_Ins    (M_Ins),
    .M_md_Y   (M_md_Y),
    .HI       (bus.hi),
    .LO       (bus.lo)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void ref_md(
    input  md_op_e      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] h,
    output logic [31:0] l,
    output bit          we);
    int          sa, sb;
    longint      p;
    logic [63:0] up;
    sa = a;
    sb = b;
    h  = mdl_hi;
    l  = mdl_lo;
    we = 1'b1;
    case (op)
      MD_MULT: begin
        p = longint'(sa) * longint'(sb);
        {h, l} = p;
      end
      MD_MULTU: begin
        up = {32'b0, a} * {32'b0, b};
        {h, l} = up;
      end
      MD_DIV: begin
        if (b == 0) we = 1'b0;
        else if (a == 32'h8000_0000 &&
                 b == 32'hFFFF_FFFF) begin
          l = a;
          h = 0;
        end else begin
          l = sa / sb;
          h = sa % sb;
        end
      end
      MD_DIVU: begin
        if (b == 0) we = 1'b0;
        else begin
          l = a / b;
          h = a % b;
        end
      end
      default: we = 1'b0;
    endcase
  endfunction

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk({tag, "_idle"}, 32'(n < 40), 32'd1);
  endtask

  task automatic run_md(input string tag,
                        input md_op_e op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input int n);
    logic [31:0] eh, el;
    bit          we;
    int          cnt;
    ref_md(op, a, b, eh, el, we);
    bus.op = op;
    bus.a  = a;
    bus.b  = b;
    #1;
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
      bus.op = MD_NONE;
      #1;
    end
    chk({tag, "_busy"}, 32'(cnt), 32'(n + 1));
    if (we) begin
      mdl_hi = eh;
      mdl_lo = el;
    end
    chk({tag, "_hi"}, bus.hi, mdl_hi);
    chk({tag, "_lo"}, bus.lo, mdl_lo);
  endtask

  initial begin
    md_op_e      ops [4];
    md_op_e      op;
    logic [31:0] ra, rb, old, eh, el;
    bit          we;

    ops = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
    reset   = 1'b1;
    bus.op  = MD_NONE;
    bus.a   = '0;
    bus.b   = '0;
    E_PC    = 32'h0000_0100;
    E_Ins   = 32'h1234_5678;
    E_clear = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_mpc", M_PC, 32'h0);
    chk("rst_mins", M_Ins, 32'h0);
    chk("rst_my", M_md_Y, 32'h0);

    run_md("mult_n2x3", MD_MULT,
           32'hFFFF_FFFE, 32'd3, 5);

    // MTHI/MTLO: zero busy, no M-side output.
    bus.op = MD_MTHI;
    bus.a  = 32'h11;
    #1;
    chk("mthi_busy", 32'(bus.busy), 32'd0);
    chk("mthi_out", E_md_out, 32'h0);
    tick();
    bus.op = MD_MTLO;
    bus.a  = 32'h22;
    tick();
    bus.op = MD_NONE;
    mdl_hi = 32'h11;
    mdl_lo = 32'h22;
    chk("mt_hi", bus.hi, mdl_hi);
    chk("mt_lo", bus.lo, mdl_lo);

    run_md("div0", MD_DIV, 32'd9, 32'd0, 10);
    run_md("divu_7_2", MD_DIVU, 32'd7, 32'd2, 10);
    run_md("div_m7_2", MD_DIV,
           32'hFFFF_FFF9, 32'd2, 10);
    run_md("div_min", MD_DIV,
           32'h8000_0000, 32'hFFFF_FFFF, 10);

    for (int i = 0; i < 12; i++) begin
      op = ops[$urandom_range(0, 3)];
      ra = $urandom;
      rb = (i % 3 == 0) ? $urandom_range(0, 7)
                        : $urandom;
      run_md($sformatf("rnd%0d", i), op, ra, rb,
             (op == MD_MULT || op == MD_MULTU)
               ? 5 : 10);
    end

    // MFLO during a multiply sees old LO.
    old    = mdl_lo;
    bus.op = MD_MULT;
    bus.a  = 32'd4;
    bus.b  = 32'd5;
    tick();
    bus.op = MD_NONE;
    tick();
    bus.op = MD_MFLO;
    #1;
    chk("mflo_busy", 32'(bus.busy), 32'd1);
    chk("mflo_old", E_md_out, old);
    tick();
    chk("mflo_old_m", M_md_Y, old);
    bus.op = MD_NONE;
    #1;
    wait_idle("mul45");
    mdl_hi = 32'h0;
    mdl_lo = 32'd20;
    bus.op = MD_MFLO;
    #1;
    chk("mflo_new", E_md_out, 32'd20);
    tick();
    chk("mflo_new_m", M_md_Y, 32'd20);

    // Pipeline registers follow E.
    E_PC   = $urandom;
    E_Ins  = $urandom;
    bus.op = MD_MFHI;
    #1;
    chk("mfhi_out", E_md_out, mdl_hi);
    tick();
    chk("pipe_pc", M_PC, E_PC);
    chk("pipe_ins", M_Ins, E_Ins);
    chk("pipe_y", M_md_Y, mdl_hi);

    // Requests while busy are ignored.
    ra = $urandom;
    rb = $urandom;
    ref_md(MD_MULTU, ra, rb, eh, el, we);
    bus.op = MD_MULTU;
    bus.a  = ra;
    bus.b  = rb;
    tick();
    bus.op = MD_MTHI;
    bus.a  = 32'h5555_5555;
    tick();
    bus.op = MD_DIV;
    bus.b  = 32'd3;
    tick();
    bus.op = MD_MTLO;
    tick();
    bus.op = MD_NONE;
    #1;
    wait_idle("ign");
    mdl_hi = eh;
    mdl_lo = el;
    chk("ign_hi", bus.hi, mdl_hi);
    chk("ign_lo", bus.lo, mdl_lo);

    // Reset in the second busy cycle.
    bus.op = MD_MULT;
    bus.a  = $urandom | 32'h1;
    bus.b  = $urandom | 32'h1;
    E_PC   = 32'h0000_0400;
    E_Ins  = 32'hDEAD_BEEF;
    tick();
    bus.op = MD_NONE;
    reset  = 1'b1;
    tick();
    reset  = 1'b0;
    #1;
    mdl_hi = '0;
    mdl_lo = '0;
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_hi", bus.hi, 32'h0);
    chk("mrst_lo", bus.lo, 32'h0);
    chk("mrst_mpc", M_PC, 32'h0);
    chk("mrst_mins", M_Ins, 32'h0);
    chk("mrst_my", M_md_Y, 32'h0);
    repeat (8) tick();
    chk("mrst_hi_late", bus.hi, 32'h0);
    chk("mrst_lo_late", bus.lo, 32'h0);

    // MTHI then MFHI with a bubble.
    bus.op = MD_MTHI;
    bus.a  = 32'h0000_ABCD;
    tick();
    bus.op  = MD_MFHI;
    E_clear = 1'b1;
    #1;
    chk("clr_out", E_md_out, 32'h0000_ABCD);
    chk("clr_hi", bus.hi, 32'h0000_ABCD);
    tick();
    chk("clr_my", M_md_Y, 32'h0);
    chk("clr_mins", M_Ins, 32'h0);
    chk("clr_mpc", M_PC, 32'h0);
    E_clear = 1'b0;
    bus.op  = MD_NONE;

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
